vga_pixel_gen: RTL and testbench
================================

// Module: vga_pixel_gen
// PURPOSE
//  Downstream of vga_controller. Turns its h_count/v_count/h_sync/v_sync into
//  pipelined 8-bit RGB (RRR_GGG_BB) pixels, plus re-aligned syncs for the DAC pins.
//  Background: 16x16-pixel tile colours fetched from an external synchronous tile RAM.
//  Foreground: one square sprite, repositioned through a valid/ready command port.
//  Sprite updates take effect only at end of frame (tear-free).
// PARAMETERS
//  H_VIS_START  184  first visible h_count (800 visible columns)
//  H_VIS_END    984  first non-visible h_count after the visible region
//  V_VIS_START  43   first visible v_count (600 visible lines)
//  V_VIS_END    643  first non-visible v_count after the visible region
//  TILE_COLS    50   tiles per row (800/16)
//  SPRITE_SIZE  32   sprite edge length, pixels
// PORTS
//  clk         in   1   pixel clock
//  reset       in   1   asynchronous, active-high
//  h_count     in   11  horizontal counter from vga_controller
//  v_count     in   11  vertical counter from vga_controller
//  h_sync_in   in   1   active-low hsync from vga_controller
//  v_sync_in   in   1   active-low vsync from vga_controller
//  tile_addr   out  11  tile RAM read address; row*TILE_COLS+col, range 0..1899
//  tile_data   in   8   tile RAM colour; valid one cycle after tile_addr is registered
//  cmd_valid   in   1   sprite update request
//  cmd_ready   out  1   high = update can be accepted
//  cmd_x       in   10  sprite left edge, visible-pixel coordinates
//  cmd_y       in   10  sprite top edge, visible-pixel coordinates
//  cmd_color   in   8   sprite colour; 8'h00 = sprite disabled
//  rgb         out  8   pixel colour
//  h_sync_out  out  1   h_sync_in delayed by 3 cycles
//  v_sync_out  out  1   v_sync_in delayed by 3 cycles
//  frame_count out  16  frames completed; wraps 0xFFFF->0
// BEHAVIOUR
//  - Reset values:
//    - rgb=0, h_sync_out=1, v_sync_out=1, tile_addr=0, frame_count=0, cmd_ready=1.
//    - Active and pending sprite: colour=0 (sprite off).
//    - Reset mid-frame aborts the pipeline immediately; no partial pixels afterwards.
//  - Pipeline, 3 cycles from input sample to rgb/syncs:
//    - S1 (edge 1):
//      - vis = (H_VIS_START<=h<H_VIS_END) && (V_VIS_START<=v<V_VIS_END).
//      - x = h-H_VIS_START and y = v-V_VIS_START, each 10 bits.
//      - tile_addr = (y>>4)*TILE_COLS + (x>>4); holds its previous value when !vis.
//    - S2 (edge 2): RAM registers tile_data. Delay vis, x, y and syncs alongside it.
//    - S3 (edge 3), priority order:
//      - !vis -> rgb=0.
//      - sprite hit -> rgb=active colour.
//      - otherwise rgb=tile_data.
//  - Sprite hit:
//    - Condition: ax<=x<ax+SIZE && ay<=y<ay+SIZE && acolor!=0.
//    - Compare in 11 bits so no wrap-around occurs.
//  - Command FSM, states IDLE and PENDING:
//    - cmd_ready = (state==IDLE).
//    - IDLE: cmd_valid=1 -> latch x/y/colour into the pending register, go to PENDING.
//    - Clamp on latch: x to 800-SIZE, y to 600-SIZE.
//    - PENDING: at frame boundary -> copy pending to active, go to IDLE.
//      cmd_ready rises on the cycle after the copy.
//    - Frame boundary = S1 sees v_count==V_VIS_END && h_count==0, once per frame.
//    - Boundary on the same cycle a command is accepted in IDLE: the command is not
//      applied until the next boundary.
//  - frame_count increments on each frame boundary.
// STRUCTURE
//  - vga_pkg holds:
//    - visible-window constants (184/984/43/643);
//    - 800/600 visible dimensions;
//    - tile shift 4;
//    - colour constant RGB_BLACK=8'h00.
//  - Sub-module vga_sprite_unit holds the command FSM, pending/active registers, clamp
//    and hit compare. Its hit output is registered into S3.
// TESTING
//  - Reset asserted mid-line -> same cycle: rgb=0, syncs=1, cmd_ready=1, frame_count=0.
//  - Sweep a full 1040x666 frame with a RAM model (colour=addr[7:0]):
//    - h=184,v=43 -> rgb=8'h00 three cycles later.
//    - h=200,v=43 -> rgb=8'h01.
//    - h=183 -> rgb=0 (blank).
//  - Sync alignment: drive h_sync_in low at cycle t -> h_sync_out low at t+3 and
//    high again exactly 3 cycles after h_sync_in rises.
//  - Command x=100,y=50,color=8'hE0 mid-frame:
//    - cmd_ready drops.
//    - Current frame shows no sprite.
//    - Next frame: pixel (100,50) and (131,81) = 8'hE0; (132,50) = tile colour.
//    - cmd_ready high again after the boundary.
//  - Command x=1000,y=700 -> clamped to (768,568); pixel (799,599) = sprite colour.
//  - Second command while PENDING: held with cmd_valid=1 and not accepted until
//    cmd_ready returns. Run 65536 boundaries -> frame_count wraps to 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA pixel pipeline (800x600 visible window).
package vga_pkg;

   // Visible window expressed in vga_controller counter units
   localparam logic [10:0] H_VIS_START = 11'd184;
   localparam logic [10:0] H_VIS_END   = 11'd984;
   localparam logic [10:0] V_VIS_START = 11'd43;
   localparam logic [10:0] V_VIS_END   = 11'd643;

   // Visible dimensions in pixels
   localparam int VIS_W = 800;
   localparam int VIS_H = 600;

   // Background tiles are 16x16 pixels
   localparam int TILE_SHIFT = 4;
   localparam int TILE_COLS  = VIS_W >> TILE_SHIFT;

   // Square sprite edge length in pixels
   localparam int SPRITE_SIZE = 32;

   // Blank colour; also the "sprite disabled" colour
   localparam logic [7:0] RGB_BLACK = 8'h00;

   // Sprite command handshake states
   typedef enum logic {
      CMD_IDLE    = 1'b0,
      CMD_PENDING = 1'b1
   } cmd_state_e;

endpackage

// File: rtl/vga_sprite_unit.sv
// Sprite command port, pending/active sprite registers and the pixel hit test.
// Commands are parked in a pending register and copied to the active register
// only at a frame boundary so the sprite never tears mid-frame.
module vga_sprite_unit
   import vga_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_boundary,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [9:0] cmd_x,
   input  logic [9:0] cmd_y,
   input  logic [7:0] cmd_color,
   input  logic [9:0] pix_x_p1,
   input  logic [9:0] pix_y_p1,
   output logic       hit_p2,
   output logic [7:0] color_p2
);

   localparam logic [9:0]  X_MAX   = 10'(VIS_W - SPRITE_SIZE);
   localparam logic [9:0]  Y_MAX   = 10'(VIS_H - SPRITE_SIZE);
   localparam logic [10:0] SIZE_11 = 11'(SPRITE_SIZE);

   // Keep the whole sprite on screen
   function automatic logic [9:0] sat_coord(input logic [9:0] val, input logic [9:0] lim);
      return (val > lim) ? lim : val;
   endfunction

   cmd_state_e  state_q, state_d;
   logic        pend_load, act_load;
   logic [9:0]  pend_x_q, pend_x_d, pend_y_q, pend_y_d;
   logic [9:0]  act_x_q, act_x_d, act_y_q, act_y_d;
   logic [7:0]  pend_color_q, pend_color_d, act_color_q, act_color_d;
   logic        hit_p2_q, hit_p2_d;
   logic [7:0]  color_p2_q, color_p2_d;
   logic [10:0] px_11, py_11, ax_11, ay_11;

   // Command FSM: accept in IDLE, promote pending to active at the frame boundary
   always_comb begin
      state_d   = state_q;
      pend_load = 1'b0;
      act_load  = 1'b0;
      if (state_q == CMD_IDLE) begin
         if (cmd_valid) begin
            pend_load = 1'b1;
            state_d   = CMD_PENDING;
         end
      end else begin
         if (frame_boundary) begin
            act_load = 1'b1;
            state_d  = CMD_IDLE;
         end
      end
   end

   assign cmd_ready = (state_q == CMD_IDLE);

   // Next values of the pending and active sprite registers
   always_comb begin
      pend_x_d     = pend_load ? sat_coord(cmd_x, X_MAX) : pend_x_q;
      pend_y_d     = pend_load ? sat_coord(cmd_y, Y_MAX) : pend_y_q;
      pend_color_d = pend_load ? cmd_color : pend_color_q;
      act_x_d      = act_load ? pend_x_q : act_x_q;
      act_y_d      = act_load ? pend_y_q : act_y_q;
      act_color_d  = act_load ? pend_color_q : act_color_q;
   end

   // FSM state and sprite colours; a zero colour keeps the sprite off after reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= CMD_IDLE;
         pend_color_q <= RGB_BLACK;
         act_color_q  <= RGB_BLACK;
      end else begin
         state_q      <= state_d;
         pend_color_q <= pend_color_d;
         act_color_q  <= act_color_d;
      end
   end

   // Sprite coordinates; meaningless while the colour is zero
   always_ff @(posedge clk) begin
      pend_x_q <= pend_x_d;
      pend_y_q <= pend_y_d;
      act_x_q  <= act_x_d;
      act_y_q  <= act_y_d;
   end

   // Hit test on the S1 pixel coordinates, widened to 11 bits so edge+SIZE never wraps
   always_comb begin
      px_11      = {1'b0, pix_x_p1};
      py_11      = {1'b0, pix_y_p1};
      ax_11      = {1'b0, act_x_q};
      ay_11      = {1'b0, act_y_q};
      hit_p2_d   = (act_color_q != RGB_BLACK) &&
                   (px_11 >= ax_11) && (px_11 < ax_11 + SIZE_11) &&
                   (py_11 >= ay_11) && (py_11 < ay_11 + SIZE_11);
      color_p2_d = act_color_q;
   end

   // ---- stage boundary S1 -> S2: hit travels alongside the tile RAM read ----
   always_ff @(posedge clk) begin
      hit_p2_q   <= hit_p2_d;
      color_p2_q <= color_p2_d;
   end

   assign hit_p2   = hit_p2_q;
   assign color_p2 = color_p2_q;

endmodule

// File: rtl/vga_pixel_gen.sv
// Three-stage pixel generator: tile background from an external synchronous RAM
// with one sprite overlaid, plus syncs re-aligned to the pixel output.
module vga_pixel_gen
   import vga_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [10:0] h_count,
   input  logic [10:0] v_count,
   input  logic        h_sync_in,
   input  logic        v_sync_in,
   output logic [10:0] tile_addr,
   input  logic [7:0]  tile_data,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [9:0]  cmd_x,
   input  logic [9:0]  cmd_y,
   input  logic [7:0]  cmd_color,
   output logic [7:0]  rgb,
   output logic        h_sync_out,
   output logic        v_sync_out,
   output logic [15:0] frame_count
);

   // Row-major tile index of the visible pixel (x, y)
   function automatic logic [10:0] tile_index(input logic [9:0] x, input logic [9:0] y);
      logic [10:0] row;
      logic [10:0] col;
      row = 11'(y >> TILE_SHIFT);
      col = 11'(x >> TILE_SHIFT);
      return row * 11'(TILE_COLS) + col;
   endfunction

   logic        vis_p1_q, vis_p1_d;
   logic [9:0]  x_p1_q, x_p1_d, y_p1_q, y_p1_d;
   logic [10:0] tile_addr_q, tile_addr_d;
   logic        hs_p1_q, hs_p1_d, vs_p1_q, vs_p1_d;
   logic        vis_p2_q, vis_p2_d;
   logic        hs_p2_q, hs_p2_d, vs_p2_q, vs_p2_d;
   logic [7:0]  rgb_q, rgb_d;
   logic        hs_out_q, hs_out_d, vs_out_q, vs_out_d;
   logic [15:0] frame_count_q, frame_count_d;
   logic        frame_boundary;
   logic        sprite_hit_p2;
   logic [7:0]  sprite_color_p2;

   // S1 inputs: visibility, visible coordinates, tile address and frame boundary
   always_comb begin
      vis_p1_d       = (h_count >= H_VIS_START) && (h_count < H_VIS_END) &&
                       (v_count >= V_VIS_START) && (v_count < V_VIS_END);
      x_p1_d         = 10'(h_count - H_VIS_START);
      y_p1_d         = 10'(v_count - V_VIS_START);
      tile_addr_d    = vis_p1_d ? tile_index(x_p1_d, y_p1_d) : tile_addr_q;
      hs_p1_d        = h_sync_in;
      vs_p1_d        = v_sync_in;
      frame_boundary = (v_count == V_VIS_END) && (h_count == 11'd0);
      frame_count_d  = frame_boundary ? frame_count_q + 16'd1 : frame_count_q;
   end

   // ---- stage boundary -> S1 (control) ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vis_p1_q      <= 1'b0;
         tile_addr_q   <= '0;
         hs_p1_q       <= 1'b1;
         vs_p1_q       <= 1'b1;
         frame_count_q <= '0;
      end else begin
         vis_p1_q      <= vis_p1_d;
         tile_addr_q   <= tile_addr_d;
         hs_p1_q       <= hs_p1_d;
         vs_p1_q       <= vs_p1_d;
         frame_count_q <= frame_count_d;
      end
   end

   // ---- stage boundary -> S1 (pixel coordinates) ----
   always_ff @(posedge clk) begin
      x_p1_q <= x_p1_d;
      y_p1_q <= y_p1_d;
   end

   vga_sprite_unit u_sprite (
      .clk            (clk),
      .reset          (reset),
      .frame_boundary (frame_boundary),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_x          (cmd_x),
      .cmd_y          (cmd_y),
      .cmd_color      (cmd_color),
      .pix_x_p1       (x_p1_q),
      .pix_y_p1       (y_p1_q),
      .hit_p2         (sprite_hit_p2),
      .color_p2       (sprite_color_p2)
   );

   // S2 delays visibility and syncs while the RAM registers tile_data
   always_comb begin
      vis_p2_d = vis_p1_q;
      hs_p2_d  = hs_p1_q;
      vs_p2_d  = vs_p1_q;
   end

   // ---- stage boundary S1 -> S2 ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vis_p2_q <= 1'b0;
         hs_p2_q  <= 1'b1;
         vs_p2_q  <= 1'b1;
      end else begin
         vis_p2_q <= vis_p2_d;
         hs_p2_q  <= hs_p2_d;
         vs_p2_q  <= vs_p2_d;
      end
   end

   // S3 colour select: blanking, then sprite, then background tile
   always_comb begin
      rgb_d    = RGB_BLACK;
      hs_out_d = hs_p2_q;
      vs_out_d = vs_p2_q;
      if (vis_p2_q) begin
         rgb_d = sprite_hit_p2 ? sprite_color_p2 : tile_data;
      end
   end

   // ---- stage boundary S2 -> S3 ----
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q    <= RGB_BLACK;
         hs_out_q <= 1'b1;
         vs_out_q <= 1'b1;
      end else begin
         rgb_q    <= rgb_d;
         hs_out_q <= hs_out_d;
         vs_out_q <= vs_out_d;
      end
   end

   assign tile_addr   = tile_addr_q;
   assign rgb         = rgb_q;
   assign h_sync_out  = hs_out_q;
   assign v_sync_out  = vs_out_q;
   assign frame_count = frame_count_q;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Bench for vga_pixel_gen: tile RAM model, pixel scoreboard and per-feature tests.
module tb_vga_pixel_gen;

   logic        clk;
   logic        reset;
   logic [10:0] h_count, v_count;
   logic        h_sync_in, v_sync_in;
   logic [10:0] tile_addr;
   logic [7:0]  tile_data;
   logic        cmd_valid, cmd_ready;
   logic [9:0]  cmd_x, cmd_y;
   logic [7:0]  cmd_color;
   logic [7:0]  rgb;
   logic        h_sync_out, v_sync_out;
   logic [15:0] frame_count;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      int         due;
      logic [7:0] val;
      int         h;
      int         v;
   } exp_t;
   exp_t sb[$];

   // Reference model of sprite state and frame counter
   bit         m_pend = 1'b0;
   int         m_px = 0, m_py = 0, m_ax = 0, m_ay = 0;
   logic [7:0] m_pc = 8'h00, m_ac = 8'h00;
   logic [15:0] m_fc = 16'h0000;

   vga_pixel_gen dut (
      .clk         (clk),
      .reset       (reset),
      .h_count     (h_count),
      .v_count     (v_count),
      .h_sync_in   (h_sync_in),
      .v_sync_in   (v_sync_in),
      .tile_addr   (tile_addr),
      .tile_data   (tile_data),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_x       (cmd_x),
      .cmd_y       (cmd_y),
      .cmd_color   (cmd_color),
      .rgb         (rgb),
      .h_sync_out  (h_sync_out),
      .v_sync_out  (v_sync_out),
      .frame_count (frame_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous tile RAM whose content is the low byte of its address
   always @(posedge clk) tile_data <= tile_addr[7:0];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: compare each expected pixel when it is due
   always @(negedge clk) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].due <= cyc) begin
         e = sb.pop_front();
         total++;
         if (rgb !== e.val) begin
            bad++;
            $display("FAIL rgb pixel h=%0d v=%0d got=%h want=%h", e.h, e.v, rgb, e.val);
         end
      end
   end

   function automatic logic [7:0] model_rgb(input int h, input int v);
      int x, y;
      if (h < 184 || h >= 984 || v < 43 || v >= 643) return 8'h00;
      x = h - 184;
      y = v - 43;
      if (m_ac != 8'h00 && x >= m_ax && x < m_ax + 32 && y >= m_ay && y < m_ay + 32)
         return m_ac;
      return 8'(((y / 16) * 50 + (x / 16)) & 255);
   endfunction

   // Drive one pixel for one clock; expected colour is queued for 3 edges later
   task automatic tick(input int h, input int v);
      exp_t e;
      bit   bnd;
      h_count = 11'(h);
      v_count = 11'(v);
      e.due = cyc + 3;
      e.val = model_rgb(h, v);
      e.h   = h;
      e.v   = v;
      sb.push_back(e);
      bnd = (h == 0 && v == 643);
      if (bnd) m_fc = m_fc + 16'd1;
      if (m_pend && bnd) begin
         m_ax = m_px; m_ay = m_py; m_ac = m_pc; m_pend = 1'b0;
      end else if (!m_pend && cmd_valid) begin
         m_px = (int'(cmd_x) > 768) ? 768 : int'(cmd_x);
         m_py = (int'(cmd_y) > 568) ? 568 : int'(cmd_y);
         m_pc = cmd_color;
         m_pend = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      repeat (4) tick(0, 0);
   endtask

   task automatic test_power_on();
      total++; if (rgb !== 8'h00) begin bad++; $display("FAIL por_rgb got=%h want=00", rgb); end
      total++; if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin bad++; $display("FAIL por_syncs got=%b%b want=11", h_sync_out, v_sync_out); end
      total++; if (tile_addr !== 11'd0) begin bad++; $display("FAIL por_tile_addr got=%0d want=0", tile_addr); end
      total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL por_frame_count got=%0d want=0", frame_count); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL por_cmd_ready got=%b want=1", cmd_ready); end
   endtask

   task automatic test_tiles();
      int pts[10][2] = '{'{184,43}, '{200,43}, '{183,43}, '{500,300}, '{215,59},
                         '{216,59}, '{984,642}, '{184,42}, '{184,643}, '{983,642}};
      foreach (pts[i]) tick(pts[i][0], pts[i][1]);
      tick(0, 0);
      total++;
      if (tile_addr !== 11'd1899) begin
         bad++; $display("FAIL tile_addr_hold got=%0d want=1899", tile_addr);
      end
      for (int h = 176; h < 264; h++) tick(h, 143);
      drain();
   endtask

   task automatic test_sync();
      h_sync_in = 1'b0;
      tick(0, 0); tick(0, 0);
      total++; if (h_sync_out !== 1'b1) begin bad++; $display("FAIL hs_fall_early got=%b want=1", h_sync_out); end
      tick(0, 0);
      total++; if (h_sync_out !== 1'b0) begin bad++; $display("FAIL hs_fall got=%b want=0", h_sync_out); end
      tick(0, 0);
      h_sync_in = 1'b1;
      tick(0, 0); tick(0, 0);
      total++; if (h_sync_out !== 1'b0) begin bad++; $display("FAIL hs_rise_early got=%b want=0", h_sync_out); end
      tick(0, 0);
      total++; if (h_sync_out !== 1'b1) begin bad++; $display("FAIL hs_rise got=%b want=1", h_sync_out); end
      v_sync_in = 1'b0;
      tick(0, 0); tick(0, 0);
      total++; if (v_sync_out !== 1'b1) begin bad++; $display("FAIL vs_fall_early got=%b want=1", v_sync_out); end
      tick(0, 0);
      total++; if (v_sync_out !== 1'b0) begin bad++; $display("FAIL vs_fall got=%b want=0", v_sync_out); end
      v_sync_in = 1'b1;
      drain();
      total++; if (v_sync_out !== 1'b1) begin bad++; $display("FAIL vs_rise got=%b want=1", v_sync_out); end
   endtask

   task automatic test_sprite();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL spr_ready_idle got=%b want=1", cmd_ready); end
      cmd_x = 10'd100; cmd_y = 10'd50; cmd_color = 8'hE0; cmd_valid = 1'b1;
      tick(300, 200);
      cmd_valid = 1'b0;
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL spr_ready_drop got=%b want=0", cmd_ready); end
      tick(284, 93); tick(315, 124); tick(316, 93); tick(600, 400);
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL spr_ready_hold got=%b want=0", cmd_ready); end
      tick(0, 643);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL spr_ready_return got=%b want=1", cmd_ready); end
      tick(284, 93); tick(315, 124); tick(316, 93); tick(283, 93); tick(284, 92); tick(315, 125);
      drain();
   endtask

   task automatic test_clamp();
      cmd_x = 10'd1000; cmd_y = 10'd700; cmd_color = 8'h1C; cmd_valid = 1'b1;
      tick(0, 0);
      cmd_valid = 1'b0;
      tick(0, 643);
      tick(983, 642); tick(952, 611); tick(951, 611); tick(952, 610);
      drain();
   endtask

   task automatic test_back_to_back();
      cmd_x = 10'd10; cmd_y = 10'd10; cmd_color = 8'h03; cmd_valid = 1'b1;
      tick(0, 0);
      cmd_x = 10'd400; cmd_y = 10'd300; cmd_color = 8'hFC;
      for (int i = 0; i < 4; i++) begin
         tick(194, 53);
         total++;
         if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_held_%0d got=%b want=0", i, cmd_ready); end
      end
      tick(0, 643);
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready_return got=%b want=1", cmd_ready); end
      tick(0, 0);
      cmd_valid = 1'b0;
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL b2b_second_accept got=%b want=0", cmd_ready); end
      tick(194, 53); tick(584, 343);
      tick(0, 643);
      tick(584, 343); tick(615, 374); tick(194, 53);
      drain();
      total++; if (frame_count !== m_fc) begin bad++; $display("FAIL b2b_frame_count got=%0d want=%0d", frame_count, m_fc); end
   endtask

   task automatic test_reset();
      h_sync_in = 1'b0; v_sync_in = 1'b0;
      cmd_x = 10'd5; cmd_y = 10'd5; cmd_color = 8'h77; cmd_valid = 1'b1;
      tick(200, 43);
      cmd_valid = 1'b0;
      tick(200, 43); tick(200, 43); tick(200, 43);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      total++; if (rgb !== 8'h00) begin bad++; $display("FAIL rst_rgb got=%h want=00", rgb); end
      total++; if (h_sync_out !== 1'b1 || v_sync_out !== 1'b1) begin bad++; $display("FAIL rst_syncs got=%b%b want=11", h_sync_out, v_sync_out); end
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_cmd_ready got=%b want=1", cmd_ready); end
      total++; if (frame_count !== 16'd0) begin bad++; $display("FAIL rst_frame_count got=%0d want=0", frame_count); end
      total++; if (tile_addr !== 11'd0) begin bad++; $display("FAIL rst_tile_addr got=%0d want=0", tile_addr); end
      m_pend = 1'b0; m_ac = 8'h00; m_pc = 8'h00; m_fc = 16'h0000;
      @(posedge clk); @(posedge clk); #1;
      h_sync_in = 1'b1; v_sync_in = 1'b1;
      reset = 1'b0;
      tick(200, 43);
      total++; if (rgb !== 8'h00) begin bad++; $display("FAIL rst_no_partial_1 got=%h want=00", rgb); end
      tick(200, 43);
      total++; if (rgb !== 8'h00) begin bad++; $display("FAIL rst_no_partial_2 got=%h want=00", rgb); end
      drain();
   endtask

   task automatic test_frame_wrap();
      for (int i = 0; i < 65535; i++) tick(0, 643);
      total++; if (frame_count !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h want=ffff", frame_count); end
      tick(0, 643);
      total++; if (frame_count !== 16'h0000) begin bad++; $display("FAIL wrap_zero got=%h want=0000", frame_count); end
      drain();
   endtask

   initial begin
      reset = 1'b1;
      h_count = 11'd0; v_count = 11'd0;
      h_sync_in = 1'b1; v_sync_in = 1'b1;
      cmd_valid = 1'b0; cmd_x = 10'd0; cmd_y = 10'd0; cmd_color = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      test_power_on();
      reset = 1'b0;
      test_tiles();
      test_sync();
      test_sprite();
      test_clamp();
      test_back_to_back();
      test_reset();
      test_frame_wrap();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
